// File: rtl/vmsx_seq_pkg.sv
// vmsx_seq_pkg -- shared types and constants for the VMSBF/VMSIF/VMSOF sequencer.
// Rev 1.0
`default_nettype none

package vmsx_seq_pkg;

   localparam int VMSX_VLEN    = 128;
   localparam int VMSX_CHUNK_W = 16;
   localparam int VMSX_VL_W    = $clog2(VMSX_VLEN) + 1;

   typedef enum logic [1:0] {
      VMSBF = 2'd0,
      VMSIF = 2'd1,
      VMSOF = 2'd2
   } instr_type_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } vmsx_state_t;

endpackage

`default_nettype wire

// File: rtl/vmsx_seq_if.sv
// vmsx_seq_if -- request/result handshake bundle of the mask-prefix sequencer.
// Rev 1.0
`default_nettype none

interface vmsx_seq_if #(
   parameter int VLEN = vmsx_seq_pkg::VMSX_VLEN
);
   import vmsx_seq_pkg::*;

   localparam int VL_W = $clog2(VLEN) + 1;

   logic              valid_i;
   logic              ready_o;
   instr_type_t       instr_type_i;
   logic [VLEN-1:0]   vs2_i;
   logic [VLEN-1:0]   vm_i;
   logic              use_mask_i;
   logic [VL_W-1:0]   vl_i;
   logic              kill_i;
   logic              valid_o;
   logic              ready_i;
   logic [VLEN-1:0]   vd_o;

   modport master (
      output valid_i, instr_type_i, vs2_i, vm_i, use_mask_i, vl_i, kill_i, ready_i,
      input  ready_o, valid_o, vd_o
   );

   modport slave (
      input  valid_i, instr_type_i, vs2_i, vm_i, use_mask_i, vl_i, kill_i, ready_i,
      output ready_o, valid_o, vd_o
   );

endinterface

`default_nettype wire

// File: rtl/vmsx_seq_chunk.sv
// vmsx_seq_chunk -- combinational set-before/including/only-first over one CHUNK_W slice.
// Rev 1.0
`default_nettype none

module vmsx_seq_chunk
   import vmsx_seq_pkg::*;
#(
   parameter int CHUNK_W = VMSX_CHUNK_W,
   parameter int VL_W    = VMSX_VL_W
) (
   input  instr_type_t        instr_i,
   input  logic [CHUNK_W-1:0] vs2_i,
   input  logic [CHUNK_W-1:0] vm_i,
   input  logic               use_mask_i,
   input  logic [VL_W-1:0]    base_i,
   input  logic [VL_W-1:0]    vl_i,
   input  logic               found_i,
   output logic [CHUNK_W-1:0] res_o,
   output logic               found_o
);

   logic w_found;
   logic w_act;
   logic w_before_val;
   logic w_at_val;

   // Unknown instruction encodings produce an all-zero result.
   assign w_before_val = (instr_i == VMSBF) || (instr_i == VMSIF);
   assign w_at_val     = (instr_i == VMSIF) || (instr_i == VMSOF);

   always_comb begin
      w_found = found_i;
      w_act   = 1'b0;
      res_o   = '0;
      for (int i = 0; i < CHUNK_W; i++) begin
         w_act = vs2_i[i] & (vm_i[i] | ~use_mask_i);
         if (((base_i + VL_W'(i)) < vl_i) && !w_found) begin
            if (w_act) begin
               w_found  = 1'b1;
               res_o[i] = w_at_val;
            end else begin
               res_o[i] = w_before_val;
            end
         end
      end
      found_o = w_found;
   end

endmodule

`default_nettype wire

// File: rtl/vmsx_seq.sv
// vmsx_seq -- multi-beat VMSBF/VMSIF/VMSOF sequencer over a full VLEN-bit mask register.
// Rev 1.0
`default_nettype none

module vmsx_seq
   import vmsx_seq_pkg::*;
#(
   parameter int VLEN    = VMSX_VLEN,
   parameter int CHUNK_W = VMSX_CHUNK_W
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   vmsx_seq_if.slave   bus
);

   localparam int NBEATS = VLEN / CHUNK_W;
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int VL_W   = $clog2(VLEN) + 1;

   vmsx_state_t       state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              found_q, found_d;
   instr_type_t       instr_q, instr_d;
   logic [VLEN-1:0]   vs2_q, vs2_d;
   logic [VLEN-1:0]   vm_q, vm_d;
   logic              use_mask_q, use_mask_d;
   logic [VL_W-1:0]   vl_q, vl_d;
   logic [VLEN-1:0]   vd_q, vd_d;

   logic [VL_W-1:0]    w_base;
   logic [VL_W-1:0]    w_next_base;
   logic               w_last;
   logic [CHUNK_W-1:0] w_res;
   logic               w_found;

   assign w_base      = VL_W'(beat_q) * VL_W'(CHUNK_W);
   assign w_next_base = w_base + VL_W'(CHUNK_W);
   assign w_last      = (w_next_base >= vl_q) || (beat_q == BEAT_W'(NBEATS - 1));

   vmsx_seq_chunk #(
      .CHUNK_W (CHUNK_W),
      .VL_W    (VL_W)
   ) u_chunk (
      .instr_i    (instr_q),
      .vs2_i      (vs2_q[w_base +: CHUNK_W]),
      .vm_i       (vm_q[w_base +: CHUNK_W]),
      .use_mask_i (use_mask_q),
      .base_i     (w_base),
      .vl_i       (vl_q),
      .found_i    (found_q),
      .res_o      (w_res),
      .found_o    (w_found)
   );

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      found_d    = found_q;
      instr_d    = instr_q;
      vs2_d      = vs2_q;
      vm_d       = vm_q;
      use_mask_d = use_mask_q;
      vl_d       = vl_q;
      vd_d       = vd_q;
      case (state_q)
         IDLE: begin
            if (bus.valid_i && !bus.kill_i) begin
               instr_d    = bus.instr_type_i;
               vs2_d      = bus.vs2_i;
               vm_d       = bus.vm_i;
               use_mask_d = bus.use_mask_i;
               vl_d       = bus.vl_i;
               vd_d       = '0;
               found_d    = 1'b0;
               beat_d     = '0;
               state_d    = (bus.vl_i == '0) ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (bus.kill_i) begin
               state_d = IDLE;
            end else begin
               vd_d[w_base +: CHUNK_W] = w_res;
               found_d = w_found;
               beat_d  = beat_q + 1'b1;
               // Once the first active bit is placed, every later element is 0 already.
               if ((w_found && !found_q) || w_last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (bus.kill_i || bus.ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         found_q    <= 1'b0;
         instr_q    <= VMSBF;
         vs2_q      <= '0;
         vm_q       <= '0;
         use_mask_q <= 1'b0;
         vl_q       <= '0;
         vd_q       <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         found_q    <= found_d;
         instr_q    <= instr_d;
         vs2_q      <= vs2_d;
         vm_q       <= vm_d;
         use_mask_q <= use_mask_d;
         vl_q       <= vl_d;
         vd_q       <= vd_d;
      end
   end

   assign bus.ready_o = (state_q == IDLE);
   assign bus.valid_o = (state_q == DONE);
   assign bus.vd_o    = vd_q;

endmodule

`default_nettype wire

// File: tb/tb_vmsx_seq.sv
// tb_vmsx_seq -- scoreboard bench for the mask-prefix sequencer (VLEN 128, CHUNK_W 16).
// Rev 1.0
`default_nettype none

module tb_vmsx_seq;
   import vmsx_seq_pkg::*;

   typedef struct {
      logic [127:0] vd;
      int           lat;
   } exp_t;

   typedef struct {
      instr_type_t  it;
      logic [127:0] vs2;
      logic [127:0] vm;
      logic         um;
      logic [7:0]   vl;
      logic [127:0] vd;
      int           lat;
   } vec_t;

   logic clk;
   logic rstn;
   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   vmsx_seq_if #(.VLEN(128)) bus ();

   vmsx_seq #(.VLEN(128), .CHUNK_W(16)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain element walk, latency from the position of the first active bit.
   function automatic exp_t model(input instr_type_t it, input logic [127:0] vs2,
                                  input logic [127:0] vm, input logic um, input logic [7:0] vl);
      exp_t r;
      bit   found = 0;
      int   fidx = 0;
      r.vd = '0;
      for (int e = 0; e < 128; e++) begin
         if (e < int'(vl) && !found) begin
            if (vs2[e] && (vm[e] || !um)) begin
               found = 1;
               fidx  = e;
               r.vd[e] = (it == VMSIF) || (it == VMSOF);
            end else begin
               r.vd[e] = (it == VMSBF) || (it == VMSIF);
            end
         end
      end
      if (vl == 0)   r.lat = 1;
      else if (found) r.lat = fidx / 16 + 2;
      else            r.lat = (int'(vl) + 15) / 16 + 1;
      return r;
   endfunction

   task automatic accept_req(input instr_type_t it, input logic [127:0] vs2, input logic [127:0] vm,
                             input logic um, input logic [7:0] vl, output bit ok);
      int n = 0;
      ok = 0;
      @(negedge clk);
      while (!bus.ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.ready_o) begin
         bus.instr_type_i = it;
         bus.vs2_i        = vs2;
         bus.vm_i         = vm;
         bus.use_mask_i   = um;
         bus.vl_i         = vl;
         bus.valid_i      = 1'b1;
         @(posedge clk);
         #1 bus.valid_i   = 1'b0;
         ok = 1;
      end
   endtask

   task automatic send(input instr_type_t it, input logic [127:0] vs2, input logic [127:0] vm,
                       input logic um, input logic [7:0] vl, input exp_t e, output bit ok);
      sb_q.push_back(e);
      accept_req(it, vs2, vm, um, vl, ok);
   endtask

   // Returns at the first falling edge where valid_o is high; lat counts edges since accept plus one.
   task automatic collect(output logic [127:0] vd, output int lat, output bit to);
      vd = '0;
      lat = 0;
      to = 1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.valid_o) begin
            vd  = bus.vd_o;
            lat = c + 1;
            to  = 0;
            break;
         end
         @(posedge clk);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #12;
      checks++;
      if (bus.ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o);
      end
      checks++;
      if (bus.valid_o !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o);
      end
      checks++;
      if (bus.vd_o !== 128'h0) begin
         errors++; $display("FAIL reset_vd: got %h want 0", bus.vd_o);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_prefix();
      vec_t         v[9];
      exp_t         e;
      logic [127:0] vd;
      int           lat;
      bit           to, ok;
      v[0] = '{VMSBF, 128'h1 << 20, 128'h0, 1'b0, 8'd128, 128'h000F_FFFF, 3};
      v[1] = '{VMSIF, 128'h1 << 20, 128'h0, 1'b0, 8'd128, 128'h001F_FFFF, 3};
      v[2] = '{VMSOF, (128'h1 << 40) | 128'h8, 128'h1 << 40, 1'b1, 8'd128, 128'h100_0000_0000, 4};
      v[3] = '{VMSBF, 128'h0, 128'h0, 1'b0, 8'd37, 128'h1F_FFFF_FFFF, 4};
      v[4] = '{VMSOF, 128'h0, 128'h0, 1'b0, 8'd37, 128'h0, 4};
      v[5] = '{VMSIF, ~128'h0, ~128'h0, 1'b0, 8'd0, 128'h0, 1};
      v[6] = '{instr_type_t'(2'd3), 128'h1 << 20, 128'h0, 1'b0, 8'd128, 128'h0, 3};
      v[7] = '{VMSIF, 128'h1 << 127, 128'h0, 1'b0, 8'd128, ~128'h0, 9};
      v[8] = '{VMSIF, 128'h1 << 100, 128'h0, 1'b0, 8'd50, 128'h3_FFFF_FFFF_FFFF, 5};
      for (int i = 0; i < 9; i++) begin
         send(v[i].it, v[i].vs2, v[i].vm, v[i].um, v[i].vl, '{v[i].vd, v[i].lat}, ok);
         collect(vd, lat, to);
         e = sb_q.pop_front();
         checks++;
         if (!ok || to) begin
            errors++; $display("FAIL prefix%0d_handshake: accepted=%0d timeout=%0d want 1/0", i, ok, to);
         end else begin
            if (vd !== e.vd) begin
               errors++; $display("FAIL prefix%0d_vd: got %h want %h", i, vd, e.vd);
            end
            checks++;
            if (lat !== e.lat) begin
               errors++; $display("FAIL prefix%0d_latency: got %0d want %0d", i, lat, e.lat);
            end
         end
      end
   endtask

   task automatic test_kill();
      bit ok;
      bit seen = 0;
      accept_req(VMSBF, 128'h0, 128'h0, 1'b0, 8'd128, ok);
      @(posedge clk);
      @(posedge clk);
      #1 bus.kill_i = 1'b1;
      @(posedge clk);
      #1 bus.kill_i = 1'b0;
      @(negedge clk);
      checks++;
      if (!ok || bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         errors++; $display("FAIL kill_busy: accepted=%0d ready=%b valid=%b want 1/1/0", ok, bus.ready_o, bus.valid_o);
      end
      repeat (12) begin
         @(negedge clk);
         if (bus.valid_o) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL kill_no_valid: valid_o seen=1 want 0");
      end
      // Kill beats valid_i in IDLE: a vl=0 request would otherwise raise valid_o next cycle.
      bus.vl_i = 8'd0; bus.valid_i = 1'b1; bus.kill_i = 1'b1;
      @(posedge clk);
      #1 bus.valid_i = 1'b0; bus.kill_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         errors++; $display("FAIL kill_idle: ready=%b valid=%b want 1/0", bus.ready_o, bus.valid_o);
      end
      bus.ready_i = 1'b0;
      accept_req(VMSBF, 128'h0, 128'h0, 1'b0, 8'd0, ok);
      @(negedge clk);
      bus.ready_i = 1'b1; bus.kill_i = 1'b1;
      @(posedge clk);
      #1 bus.kill_i = 1'b0;
      @(negedge clk);
      checks++;
      if (!ok || bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         errors++; $display("FAIL kill_done: accepted=%0d ready=%b valid=%b want 1/1/0", ok, bus.ready_o, bus.valid_o);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      accept_req(VMSBF, 128'h0, 128'h0, 1'b0, 8'd128, ok);
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (!ok || bus.vd_o !== 128'hFFFF_FFFF || bus.ready_o !== 1'b0) begin
         errors++; $display("FAIL midbusy_state: accepted=%0d vd=%h ready=%b want 1/ffffffff/0", ok, bus.vd_o, bus.ready_o);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         errors++; $display("FAIL async_reset_ctl: ready=%b valid=%b want 1/0", bus.ready_o, bus.valid_o);
      end
      checks++;
      if (bus.vd_o !== 128'h0) begin
         errors++; $display("FAIL async_reset_vd: got %h want 0", bus.vd_o);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_backpressure();
      exp_t         e;
      logic [127:0] vd;
      int           lat;
      bit           to, ok;
      bus.ready_i = 1'b0;
      send(VMSIF, 128'h1 << 20, 128'h0, 1'b0, 8'd128, '{128'h001F_FFFF, 3}, ok);
      collect(vd, lat, to);
      e = sb_q.pop_front();
      checks++;
      if (!ok || to || vd !== e.vd || lat !== e.lat) begin
         errors++; $display("FAIL bp_first: vd=%h lat=%0d to=%0d want %h/%0d/0", vd, lat, to, e.vd, e.lat);
      end
      sb_q.push_back('{128'h20, 2});
      bus.instr_type_i = VMSOF; bus.vs2_i = 128'h20; bus.vm_i = 128'h0;
      bus.use_mask_i = 1'b0; bus.vl_i = 8'd128; bus.valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus.valid_o !== 1'b1) begin
            errors++; $display("FAIL bp_valid%0d: got %b want 1", c, bus.valid_o);
         end
         checks++;
         if (bus.vd_o !== 128'h001F_FFFF) begin
            errors++; $display("FAIL bp_vd%0d: got %h want 1fffff", c, bus.vd_o);
         end
         checks++;
         if (bus.ready_o !== 1'b0) begin
            errors++; $display("FAIL bp_ready%0d: got %b want 0", c, bus.ready_o);
         end
      end
      bus.ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         errors++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", bus.ready_o, bus.valid_o);
      end
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      collect(vd, lat, to);
      e = sb_q.pop_front();
      checks++;
      if (to || vd !== e.vd || lat !== e.lat) begin
         errors++; $display("FAIL bp_second: vd=%h lat=%0d to=%0d want %h/%0d/0", vd, lat, to, e.vd, e.lat);
      end
   endtask

   task automatic test_back_to_back();
      exp_t         e;
      logic [127:0] vd, vs2, vm;
      int           lat;
      bit           to, ok, um;
      instr_type_t  it;
      logic [7:0]   vl;
      for (int i = 0; i < 10; i++) begin
         vs2 = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom}
             & {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
         if (i == 3) vs2 = '0;
         vm  = {$urandom, $urandom, $urandom, $urandom};
         um  = 1'($urandom_range(0, 1));
         vl  = 8'($urandom_range(0, 128));
         it  = instr_type_t'(2'($urandom_range(0, 3)));
         send(it, vs2, vm, um, vl, model(it, vs2, vm, um, vl), ok);
         collect(vd, lat, to);
         e = sb_q.pop_front();
         checks++;
         if (!ok || to || vd !== e.vd) begin
            errors++; $display("FAIL b2b%0d_vd: got %h want %h (accepted=%0d timeout=%0d)", i, vd, e.vd, ok, to);
         end
         checks++;
         if (lat !== e.lat) begin
            errors++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, e.lat);
         end
      end
   endtask

   initial begin
      bus.valid_i      = 1'b0;
      bus.instr_type_i = VMSBF;
      bus.vs2_i        = '0;
      bus.vm_i         = '0;
      bus.use_mask_i   = 1'b0;
      bus.vl_i         = '0;
      bus.kill_i       = 1'b0;
      bus.ready_i      = 1'b1;
      test_reset();
      test_prefix();
      test_kill();
      test_async_reset();
      test_backpressure();
      test_back_to_back();
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/vmsx_seq.md
# vmsx_seq

Multi-beat sequencer for the RVV mask-prefix instructions VMSBF, VMSIF and VMSOF over a full VLEN-bit mask register. The combinational set-before/including/only-first unit covers one narrow slice; this block walks that logic across the register CHUNK_W elements per cycle. It carries the "first active element found" state between beats, terminates early once the answer is fixed, and hands a complete VLEN-bit result to the SIMD writeback path through a valid/ready handshake.

## Interface
- VLEN, default drac_pkg VLEN (128): mask register width in elements.
- CHUNK_W, default 16: elements processed per beat. VLEN % CHUNK_W == 0.
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request.
- instr_type_i  in  instr_type_t  VMSBF / VMSIF / VMSOF. Any other value is accepted and yields vd = 0.
- vs2_i  in  VLEN  source mask.
- vm_i  in  VLEN  v0 mask.
- use_mask_i  in  1  masked operation (vm = 0 encoding).
- vl_i  in  $clog2(VLEN)+1  active vector length.
- kill_i  in  1  flush: abort the in-flight request.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- vd_o  out  VLEN  result mask.

## Operation
- FSM states: IDLE, BUSY, DONE.
- ready_o = 1 only in IDLE.
- IDLE → BUSY when valid_i & ready_o.
  - Latch instr, vs2, vm, use_mask and vl.
  - Clear vd_q, found_q and beat_q.
  - If vl_i == 0, go directly IDLE → DONE with vd = 0.
- BUSY processes one beat per cycle on elements [beat_q*CHUNK_W, beat_q*CHUNK_W + CHUNK_W - 1].
  - Active bit per element: vs2 & (vm | ~use_mask).
  - Only elements < vl participate. Tail elements (≥ vl) get result 0.
- Rules for participating element e, in ascending order:
  - Before the first active bit:
    - VMSBF/VMSIF: result 1. This includes mask-inactive elements.
    - VMSOF: result 0.
  - At the first active bit:
    - VMSIF/VMSOF: result 1.
    - VMSBF: result 0.
  - After the first active bit: result 0 for all three.
- found_q is set when a beat contains the first active bit.
- BUSY → DONE when any of the following holds after the current beat:
  - the first active bit was found in this beat, or
  - (beat_q+1)*CHUNK_W ≥ vl, or
  - beat_q == VLEN/CHUNK_W − 1.
- Bits not yet written stay 0 (cleared at accept).
- No active bit within vl:
  - VMSBF/VMSIF: bits [vl−1:0] = 1.
  - VMSOF: all bits 0.
- DONE:
  - valid_o = 1 and vd_o = vd_q, both held stable.
  - DONE → IDLE on ready_i.
- kill_i in BUSY or DONE: next state IDLE, valid_o drops, the result is discarded.
- kill_i in IDLE: has priority over valid_i; no accept.
- kill_i on the same cycle as the DONE handshake: kill wins, and the transfer is treated as not completed.
- Reset: state IDLE, valid_o = 0, ready_o = 1, vd_o = 0, found_q = 0, beat_q = 0.
- Reset mid-operation behaves exactly as reset from any state.

## Timing
- Accept at clock edge t0. Beat k is processed in cycle t0+1+k.
- valid_o rises at t0 + B + 1, where B = number of beats executed (1..VLEN/CHUNK_W).
  - Worst case VLEN = 128, CHUNK_W = 16: valid_o at t0+9.
  - vl == 0: valid_o at t0+1.
- Outputs are registered. No combinational path from inputs to valid_o or vd_o.
- ready_o depends on state only. It does not depend on ready_i; there is no pipelining of back-to-back requests.
- Minimum initiation interval: B + 2 cycles.

## Structure
- drac_pkg additions:
  - vmsx_state_t enum {IDLE, BUSY, DONE}.
  - VMSX_CHUNK_W = 16.
  - The vl width constant.
- Sub-module vmsx_chunk, purely combinational.
  - Inputs: instr type, CHUNK_W vs2/vm bits, use_mask, element base index, vl, found_in.
  - Outputs: CHUNK_W result bits, found_out.
- The sequencer owns the FSM, the beat counter, the operand and result registers, and early termination.

## Test plan
All scenarios use VLEN = 128, CHUNK_W = 16.
- VMSBF, unmasked, vs2 = bit 20 only, vl = 128 → vd = 0x000F_FFFF, valid_o at t0+3, 2 beats.
- VMSIF, same stimulus → vd = 0x001F_FFFF, valid_o at t0+3.
- VMSOF, masked, vs2 bits {3, 40}, vm bit3 = 0, bit40 = 1, vl = 128 → vd = bit 40 only, valid_o at t0+4.
- VMSBF, vs2 = 0, vl = 37 → vd = 0x1F_FFFF_FFFF, valid_o at t0+4; same stimulus with VMSOF → vd = 0.
- vl = 0 → valid_o at t0+1, vd = 0. kill_i at t0+3 of an 8-beat job → state IDLE at t0+4, valid_o never asserts, ready_o = 1. rstn_i low mid-BUSY → all outputs at reset values immediately.
- ready_i held low 5 cycles in DONE → vd_o and valid_o stable, ready_o = 0, concurrent valid_i ignored; ready_i high → IDLE next cycle, then the new request is accepted.
